// File: rtl/key_press_multi_if.sv
// Key-input bundle between board buttons and game control: raw keys and repeat enables in,
// debounced press/release pulses, stable level and any_press out; no backpressure.
interface key_press_multi_if #(
    parameter int N_KEYS = 4
) ();
    logic [N_KEYS-1:0] key_sw;
    logic [N_KEYS-1:0] repeat_en;
    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] level;
    logic              any_press;

    modport master (
        output key_sw, repeat_en,
        input  press, key_release, level, any_press
    );

    modport slave (
        input  key_sw, repeat_en,
        output press, key_release, level, any_press
    );
endinterface

// File: rtl/key_press_multi.sv
// Per-key 2-flop sync + debounce FSM with auto-repeat; press/level appear HOLD_DELAY+2 edges
// after the key settles, release is symmetric. Outputs are pure pulses, no backpressure.
module key_press_multi #(
    parameter int N_KEYS        = 4,
    parameter int HOLD_DELAY    = 420000,
    parameter int REPEAT_DELAY  = 8400000,
    parameter int REPEAT_PERIOD = 2100000,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    key_press_multi_if.slave kp
);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_FIRST   = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_PERIODIC = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;
    typedef enum logic {FIRST = 1'b0, PERIODIC = 1'b1} phase_t;

    logic [N_KEYS-1:0] s1_q, s1_d, s2_q, s2_d;
    state_t            state_q [N_KEYS];
    state_t            state_d [N_KEYS];
    logic [CNT_W-1:0]  dcnt_q  [N_KEYS];
    logic [CNT_W-1:0]  dcnt_d  [N_KEYS];
    logic [CNT_W-1:0]  rcnt_q  [N_KEYS];
    logic [CNT_W-1:0]  rcnt_d  [N_KEYS];
    phase_t            phase_q [N_KEYS];
    phase_t            phase_d [N_KEYS];
    logic [N_KEYS-1:0] press_q, press_d;
    logic [N_KEYS-1:0] rel_q, rel_d;
    logic              any_press_q, any_press_d;
    logic [N_KEYS-1:0] level_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            press_q     <= '0;
            rel_q       <= '0;
            any_press_q <= 1'b0;
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i] <= IDLE;
                dcnt_q[i]  <= '0;
                rcnt_q[i]  <= '0;
                phase_q[i] <= FIRST;
            end
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            press_q     <= press_d;
            rel_q       <= rel_d;
            any_press_q <= any_press_d;
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i] <= state_d[i];
                dcnt_q[i]  <= dcnt_d[i];
                rcnt_q[i]  <= rcnt_d[i];
                phase_q[i] <= phase_d[i];
            end
        end
    end

    // Debounce: the counter runs while the synced key disagrees with the accepted state.
    always_comb begin
        s1_d = kp.key_sw;
        s2_d = s1_q;
        for (int i = 0; i < N_KEYS; i++) begin
            state_d[i] = state_q[i];
            dcnt_d[i]  = dcnt_q[i];
            if (s2_q[i] == (state_q[i] == HELD)) begin
                dcnt_d[i] = '0;
            end else if (dcnt_q[i] == HOLD_LAST) begin
                dcnt_d[i]  = '0;
                state_d[i] = (state_q[i] == IDLE) ? HELD : IDLE;
            end else begin
                dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        press_d = '0;
        rel_d   = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            rcnt_d[i]  = rcnt_q[i];
            phase_d[i] = phase_q[i];
            level_vec[i] = (state_q[i] == HELD);
            if (state_q[i] == IDLE) begin
                rcnt_d[i]  = '0;
                phase_d[i] = FIRST;
                if (s2_q[i] && dcnt_q[i] == HOLD_LAST) begin
                    press_d[i] = 1'b1;
                end
            end else begin
                if (!s2_q[i] && dcnt_q[i] == HOLD_LAST) begin
                    rel_d[i] = 1'b1;
                end
                // Repeat timer freezes during release debounce so it cannot fire then.
                if (!kp.repeat_en[i]) begin
                    rcnt_d[i]  = '0;
                    phase_d[i] = FIRST;
                end else if (s2_q[i]) begin
                    if (phase_q[i] == FIRST && rcnt_q[i] == REP_FIRST) begin
                        press_d[i] = 1'b1;
                        rcnt_d[i]  = '0;
                        phase_d[i] = PERIODIC;
                    end else if (phase_q[i] == PERIODIC && rcnt_q[i] == REP_PERIODIC) begin
                        press_d[i] = 1'b1;
                        rcnt_d[i]  = '0;
                    end else begin
                        rcnt_d[i] = rcnt_q[i] + 1'b1;
                    end
                end
            end
        end
        any_press_d = |press_d;
    end

    assign kp.press       = press_q;
    assign kp.key_release = rel_q;
    assign kp.level       = level_vec;
    assign kp.any_press   = any_press_q;
endmodule

// File: tb/tb_key_press_multi.sv
// Directed vectors with hand-computed per-edge expectations; a monitor pops and compares
// after every clock edge.
module tb_key_press_multi;
    typedef struct packed {
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] level;
        logic       any;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    key_press_multi_if #(.N_KEYS(4)) kif ();

    key_press_multi #(
        .N_KEYS(4), .HOLD_DELAY(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .CNT_W(8)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .kp (kif.slave)
    );

    always #5 clk = ~clk;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    always @(posedge clk) begin
        exp_t  e;
        exp_t  act;
        string nm;
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            act.press = kif.press;
            act.rel   = kif.key_release;
            act.level = kif.level;
            act.any   = kif.any_press;
            n_vec++;
            if (act !== e) begin
                n_err++;
                $display("FAIL %s @%0t: got press=%b rel=%b level=%b any=%b, want press=%b rel=%b level=%b any=%b",
                         nm, $time, act.press, act.rel, act.level, act.any,
                         e.press, e.rel, e.level, e.any);
            end
        end
    end

    task automatic v(input logic r, input logic [3:0] k, input logic [3:0] en,
                     input logic [3:0] ep, input logic [3:0] er, input logic [3:0] el,
                     input string nm);
        exp_t e;
        @(negedge clk);
        rst           = r;
        kif.key_sw    = k;
        kif.repeat_en = en;
        e.press = ep;
        e.rel   = er;
        e.level = el;
        e.any   = |ep;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic run(input int n, input logic r, input logic [3:0] k, input logic [3:0] en,
                       input logic [3:0] el, input string nm);
        repeat (n) v(r, k, en, 4'b0000, 4'b0000, el, nm);
    endtask

    task automatic rst_seq();
        run(2, 1'b1, 4'b0000, 4'b0000, 4'b0000, "reset");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "timeout");
    end

    initial begin
        kif.key_sw    = '0;
        kif.repeat_en = '0;

        // Clean press, hold without repeat, then release
        rst_seq();
        run(5, 1'b0, 4'b0001, 4'b0000, 4'b0000, "s1_debounce");
        v(1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, "s1_press");
        run(14, 1'b0, 4'b0001, 4'b0000, 4'b0001, "s1_hold_norepeat");
        run(5, 1'b0, 4'b0000, 4'b0000, 4'b0001, "s1_release_debounce");
        v(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, "s1_release");
        run(3, 1'b0, 4'b0000, 4'b0000, 4'b0000, "s1_idle");

        // Bounce restarts the count; a 1-cycle glitch while held is ignored
        rst_seq();
        run(3, 1'b0, 4'b0001, 4'b0000, 4'b0000, "s2_bounce_hi");
        run(1, 1'b0, 4'b0000, 4'b0000, 4'b0000, "s2_bounce_lo");
        run(5, 1'b0, 4'b0001, 4'b0000, 4'b0000, "s2_rearm");
        v(1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, "s2_press");
        run(3, 1'b0, 4'b0001, 4'b0000, 4'b0001, "s2_held");
        run(1, 1'b0, 4'b0000, 4'b0000, 4'b0001, "s2_glitch");
        run(8, 1'b0, 4'b0001, 4'b0000, 4'b0001, "s2_glitch_reject");

        // Auto-repeat: P, P+10, P+13; disable at P+14; re-enable restarts full delay
        rst_seq();
        run(5, 1'b0, 4'b0001, 4'b0001, 4'b0000, "s3_debounce");
        v(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, "s3_press");
        run(9, 1'b0, 4'b0001, 4'b0001, 4'b0001, "s3_wait_first");
        v(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, "s3_rep1");
        run(2, 1'b0, 4'b0001, 4'b0001, 4'b0001, "s3_wait_period");
        v(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, "s3_rep2");
        run(7, 1'b0, 4'b0001, 4'b0000, 4'b0001, "s3_rep_disabled");
        run(9, 1'b0, 4'b0001, 4'b0001, 4'b0001, "s3_reenable_wait");
        v(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, "s3_rep_restart");
        run(5, 1'b0, 4'b0000, 4'b0001, 4'b0001, "s3_rel_no_repeat");
        v(1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, "s3_release");
        run(3, 1'b0, 4'b0000, 4'b0001, 4'b0000, "s3_idle");

        // Two channels pressed together, only ch3 repeats
        rst_seq();
        run(5, 1'b0, 4'b1010, 4'b1000, 4'b0000, "s4_debounce");
        v(1'b0, 4'b1010, 4'b1000, 4'b1010, 4'b0000, 4'b1010, "s4_press_both");
        run(9, 1'b0, 4'b1010, 4'b1000, 4'b1010, "s4_wait");
        v(1'b0, 4'b1010, 4'b1000, 4'b1000, 4'b0000, 4'b1010, "s4_rep_ch3_a");
        run(2, 1'b0, 4'b1010, 4'b1000, 4'b1010, "s4_gap_a");
        v(1'b0, 4'b1010, 4'b1000, 4'b1000, 4'b0000, 4'b1010, "s4_rep_ch3_b");
        run(2, 1'b0, 4'b1010, 4'b1000, 4'b1010, "s4_gap_b");
        v(1'b0, 4'b1010, 4'b1000, 4'b1000, 4'b0000, 4'b1010, "s4_rep_ch3_c");
        run(1, 1'b0, 4'b1010, 4'b1000, 4'b1010, "s4_tail");

        // Reset with ch2 held and ch1 mid-debounce, keys kept high
        rst_seq();
        run(5, 1'b0, 4'b0100, 4'b0000, 4'b0000, "s5_debounce_ch2");
        v(1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0100, "s5_press_ch2");
        run(2, 1'b0, 4'b0100, 4'b0000, 4'b0100, "s5_hold_ch2");
        run(4, 1'b0, 4'b0110, 4'b0000, 4'b0100, "s5_ch1_partial");
        v(1'b1, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "s5_reset_midstream");
        run(5, 1'b0, 4'b0110, 4'b0000, 4'b0000, "s5_post_reset_debounce");
        v(1'b0, 4'b0110, 4'b0000, 4'b0110, 4'b0000, 4'b0110, "s5_fresh_press");
        run(2, 1'b0, 4'b0110, 4'b0000, 4'b0110, "s5_tail");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
